// File: rtl/rom_access_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the program ROM.
// slave = arbiter side, master = CPU control unit + ROM side.
interface rom_access_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_data;

    logic              dr_req;
    logic [ADDR_W-1:0] dr_addr;
    logic              dr_gnt;
    logic              dr_valid;
    logic [DATA_W-1:0] dr_data;

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_valid, if_data,
        input  dr_req, dr_addr,
        output dr_gnt, dr_valid, dr_data,
        output rom_addr, rom_rd,
        input  rom_data
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_valid, if_data,
        output dr_req, dr_addr,
        input  dr_gnt, dr_valid, dr_data,
        input  rom_addr, rom_rd,
        output rom_data
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// Shares the program ROM between instruction fetch and MOVC reads,
// with an owner-tagged response pipeline and a post-reset init hold-off.
module rom_access_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 8,
    parameter int RD_LATENCY    = 1,
    parameter int INIT_CYCLES   = 2,
    parameter int MAX_DR_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    rom_access_arbiter_if.slave bus
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam int SW = (MAX_DR_STREAK > 0) ? $clog2(MAX_DR_STREAK + 1) : 1;
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam bit HAS_CAP = (MAX_DR_STREAK != 0);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DR_STREAK);
    localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYCLES - 1);

    state_t                r_state;
    logic [IW-1:0]         r_init_cnt;
    logic [SW-1:0]         r_streak;
    logic [RD_LATENCY-1:0] r_tag_v;
    logic [RD_LATENCY-1:0] r_tag_dr;
    logic [ADDR_W-1:0]     r_rom_addr;
    logic                  r_if_valid;
    logic                  r_dr_valid;
    logic [DATA_W-1:0]     r_if_data;
    logic [DATA_W-1:0]     r_dr_data;

    logic                  w_run;
    logic                  w_fetch_turn;
    logic                  w_if_gnt;
    logic                  w_dr_gnt;
    logic                  w_rd;
    logic [ADDR_W-1:0]     w_addr;
    logic [RD_LATENCY-1:0] w_tag_live;
    logic                  w_exit_if;
    logic                  w_exit_dr;

    assign w_run        = (r_state == S_RUN) && !rst;
    assign w_fetch_turn = HAS_CAP && (r_streak == STREAK_MAX);
    assign w_dr_gnt     = w_run && bus.dr_req
                        && !(bus.if_req && w_fetch_turn);
    assign w_if_gnt     = w_run && bus.if_req && !w_dr_gnt;
    assign w_rd         = w_if_gnt || w_dr_gnt;

    always_comb begin
        w_addr = r_rom_addr;
        case (1'b1)
            w_dr_gnt: w_addr = bus.dr_addr;
            w_if_gnt: w_addr = bus.if_addr;
            default:  w_addr = r_rom_addr;
        endcase
    end

    // A flush kills fetch tags at every stage, including the one leaving.
    assign w_tag_live = r_tag_v & ~({RD_LATENCY{bus.if_flush}} & ~r_tag_dr);
    assign w_exit_if  = w_tag_live[RD_LATENCY-1] && !r_tag_dr[RD_LATENCY-1];
    assign w_exit_dr  = w_tag_live[RD_LATENCY-1] && r_tag_dr[RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_streak   <= '0;
            r_tag_v    <= '0;
            r_tag_dr   <= '0;
            r_rom_addr <= '0;
            r_if_valid <= 1'b0;
            r_dr_valid <= 1'b0;
            r_if_data  <= '0;
            r_dr_data  <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == INIT_LAST) r_state <= S_RUN;
                    else r_init_cnt <= r_init_cnt + 1'b1;
                end
                S_RUN:   r_state <= S_RUN;
                default: r_state <= S_INIT;
            endcase

            if (w_if_gnt || !bus.if_req)
                r_streak <= '0;
            else if (w_dr_gnt && HAS_CAP && r_streak != STREAK_MAX)
                r_streak <= r_streak + 1'b1;

            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                r_tag_v[i]  <= w_tag_live[i-1];
                r_tag_dr[i] <= r_tag_dr[i-1];
            end
            r_tag_v[0]  <= w_rd;
            r_tag_dr[0] <= w_dr_gnt;

            if (w_rd) r_rom_addr <= w_addr;

            r_if_valid <= w_exit_if;
            r_dr_valid <= w_exit_dr;
            if (w_exit_if) r_if_data <= bus.rom_data;
            if (w_exit_dr) r_dr_data <= bus.rom_data;
        end
    end

    assign bus.if_gnt   = w_if_gnt;
    assign bus.dr_gnt   = w_dr_gnt;
    assign bus.rom_rd   = w_rd;
    assign bus.rom_addr = w_addr;
    assign bus.if_valid = r_if_valid;
    assign bus.dr_valid = r_dr_valid;
    assign bus.if_data  = r_if_data;
    assign bus.dr_data  = r_dr_data;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: a capped-streak instance (4)
// and a strict data-priority instance (0) behind a 1-cycle ROM model.
module tb_rom_access_arbiter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [7:0] mem [0:4095];

    rom_access_arbiter_if #(.ADDR_W(12), .DATA_W(8)) ba ();
    rom_access_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bb ();

    rom_access_arbiter #(
        .ADDR_W(12), .DATA_W(8), .RD_LATENCY(1),
        .INIT_CYCLES(2), .MAX_DR_STREAK(4)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(ba)
    );

    rom_access_arbiter #(
        .ADDR_W(12), .DATA_W(8), .RD_LATENCY(1),
        .INIT_CYCLES(2), .MAX_DR_STREAK(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(bb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ba.rom_rd) ba.rom_data <= mem[ba.rom_addr];
        if (bb.rom_rd) bb.rom_data <= mem[bb.rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"},   32'(ba.if_gnt),   32'h0);
        chk({tag, "_dr_gnt"},   32'(ba.dr_gnt),   32'h0);
        chk({tag, "_if_valid"}, 32'(ba.if_valid), 32'h0);
        chk({tag, "_dr_valid"}, 32'(ba.dr_valid), 32'h0);
        chk({tag, "_if_data"},  32'(ba.if_data),  32'h0);
        chk({tag, "_dr_data"},  32'(ba.dr_data),  32'h0);
        chk({tag, "_rom_rd"},   32'(ba.rom_rd),   32'h0);
        chk({tag, "_rom_addr"}, 32'(ba.rom_addr), 32'h0);
    endtask

    logic [7:0] m3;
    logic [7:0] m5;
    bit         f_turn;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[0] = 8'h24;
        mem[1] = 8'h05;
        mem[2] = 8'h20;
        m3 = 8'h03 ^ 8'hA5;
        m5 = 8'h05 ^ 8'hA5;

        rst = 1'b1;
        ba.if_req = 0; ba.if_addr = '0; ba.if_flush = 0;
        ba.dr_req = 0; ba.dr_addr = '0; ba.rom_data = '0;
        bb.if_req = 0; bb.if_addr = '0; bb.if_flush = 0;
        bb.dr_req = 0; bb.dr_addr = '0; bb.rom_data = '0;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            cyc();
            mid();
            chk_all_zero("reset");
        end

        // init hold-off, then fetch stream 0,1,2
        cyc(); rst = 1'b0; ba.if_req = 1; ba.if_addr = 12'h000;
        mid(); chk("init_c1_if_gnt", 32'(ba.if_gnt), 32'h0);
        chk("init_c1_rom_rd", 32'(ba.rom_rd), 32'h0);
        cyc();
        mid(); chk("init_c2_if_gnt", 32'(ba.if_gnt), 32'h0);
        cyc();
        mid(); chk("run_c3_if_gnt", 32'(ba.if_gnt), 32'h1);
        chk("run_c3_rom_rd", 32'(ba.rom_rd), 32'h1);
        chk("run_c3_rom_addr", 32'(ba.rom_addr), 32'h000);
        cyc(); ba.if_addr = 12'h001;
        mid(); chk("fs_c4_if_gnt", 32'(ba.if_gnt), 32'h1);
        chk("fs_c4_rom_addr", 32'(ba.rom_addr), 32'h001);
        chk("fs_c4_if_valid", 32'(ba.if_valid), 32'h0);
        cyc(); ba.if_addr = 12'h002;
        mid(); chk("fs_c5_if_valid", 32'(ba.if_valid), 32'h1);
        chk("fs_c5_if_data", 32'(ba.if_data), 32'h24);
        cyc(); ba.if_req = 0;
        mid(); chk("fs_c6_if_valid", 32'(ba.if_valid), 32'h1);
        chk("fs_c6_if_data", 32'(ba.if_data), 32'h05);
        chk("fs_c6_rom_rd", 32'(ba.rom_rd), 32'h0);
        chk("fs_c6_rom_addr_hold", 32'(ba.rom_addr), 32'h002);
        cyc();
        mid(); chk("fs_c7_if_valid", 32'(ba.if_valid), 32'h1);
        chk("fs_c7_if_data", 32'(ba.if_data), 32'h20);
        cyc();
        mid(); chk("fs_c8_if_valid", 32'(ba.if_valid), 32'h0);
        chk("fs_c8_if_data_hold", 32'(ba.if_data), 32'h20);

        // contention: capped streak on A, strict priority on B
        for (int i = 0; i < 10; i++) begin
            cyc();
            ba.if_req = 1; ba.if_addr = 12'h003;
            ba.dr_req = 1; ba.dr_addr = 12'h005;
            bb.if_req = 1; bb.if_addr = 12'h003;
            bb.dr_req = 1; bb.dr_addr = 12'h005;
            mid();
            f_turn = ((i % 5) == 4);
            chk($sformatf("cont%0d_a_if_gnt", i), 32'(ba.if_gnt), 32'(f_turn));
            chk($sformatf("cont%0d_a_dr_gnt", i), 32'(ba.dr_gnt), 32'(!f_turn));
            chk($sformatf("cont%0d_b_if_gnt", i), 32'(bb.if_gnt), 32'h0);
            chk($sformatf("cont%0d_b_dr_gnt", i), 32'(bb.dr_gnt), 32'h1);
            if (i == 2) begin
                chk("cont2_a_dr_valid", 32'(ba.dr_valid), 32'h1);
                chk("cont2_a_dr_data", 32'(ba.dr_data), 32'(m5));
            end
            if (i == 6) begin
                chk("cont6_a_if_valid", 32'(ba.if_valid), 32'h1);
                chk("cont6_a_if_data", 32'(ba.if_data), 32'(m3));
                chk("cont6_a_dr_valid", 32'(ba.dr_valid), 32'h0);
            end
        end
        cyc();
        ba.if_req = 0; ba.dr_req = 0; bb.if_req = 0; bb.dr_req = 0;
        cyc();
        cyc();

        // flush kills @1, keeps @2 granted in the flush cycle
        cyc(); ba.if_req = 1; ba.if_addr = 12'h001;
        mid(); chk("fl_f0_if_gnt", 32'(ba.if_gnt), 32'h1);
        cyc(); ba.if_addr = 12'h002; ba.if_flush = 1;
        mid(); chk("fl_f1_if_gnt", 32'(ba.if_gnt), 32'h1);
        cyc(); ba.if_req = 0; ba.if_flush = 0;
        mid(); chk("fl_f2_if_valid", 32'(ba.if_valid), 32'h0);
        chk("fl_f2_if_data_hold", 32'(ba.if_data), 32'(m3));
        cyc();
        mid(); chk("fl_f3_if_valid", 32'(ba.if_valid), 32'h1);
        chk("fl_f3_if_data", 32'(ba.if_data), 32'h20);
        cyc();
        mid(); chk("fl_f4_if_valid", 32'(ba.if_valid), 32'h0);

        // mixed ownership with a flush
        cyc(); ba.dr_req = 1; ba.dr_addr = 12'h000;
        mid(); chk("mx_m0_dr_gnt", 32'(ba.dr_gnt), 32'h1);
        cyc(); ba.dr_req = 0; ba.if_req = 1; ba.if_addr = 12'h001;
        ba.if_flush = 1;
        mid(); chk("mx_m1_if_gnt", 32'(ba.if_gnt), 32'h1);
        cyc(); ba.if_req = 0; ba.if_flush = 0;
        mid(); chk("mx_m2_dr_valid", 32'(ba.dr_valid), 32'h1);
        chk("mx_m2_dr_data", 32'(ba.dr_data), 32'h24);
        chk("mx_m2_if_valid", 32'(ba.if_valid), 32'h0);
        cyc();
        mid(); chk("mx_m3_if_valid", 32'(ba.if_valid), 32'h1);
        chk("mx_m3_if_data", 32'(ba.if_data), 32'h05);
        chk("mx_m3_dr_valid", 32'(ba.dr_valid), 32'h0);
        chk("mx_m3_dr_data", 32'(ba.dr_data), 32'h24);

        // reset while a read is in flight
        cyc(); ba.if_req = 1; ba.if_addr = 12'h002;
        mid(); chk("rf_x0_if_gnt", 32'(ba.if_gnt), 32'h1);
        cyc(); ba.if_req = 0; rst = 1'b1;
        mid(); chk("rf_x1_rom_rd", 32'(ba.rom_rd), 32'h0);
        cyc(); rst = 1'b0;
        mid(); chk_all_zero("rf_x2");
        cyc();
        mid(); chk("rf_x3_if_valid", 32'(ba.if_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Sequences and shares the 4K x 8 program ROM between two requesters: the instruction-fetch unit (PC-driven opcode/operand fetch) and the MOVC data-read path.
- Issues at most one ROM read per cycle, tracks in-flight reads by owner through a tag pipeline and returns each byte to the owner.
- Holds off all access after reset while the ROM initialises.
- Sits between the CPU control unit and the ROM module.

Parameters:
- ADDR_W, 12, ROM address width.
- DATA_W, 8, ROM data width.
- RD_LATENCY, 1, ROM cycles from rd-sampled edge to data valid on rom_data (1..3).
- INIT_CYCLES, 2, cycles after reset deassertion before the first grant (1..15).
- MAX_DR_STREAK, 4, consecutive data grants allowed while fetch waits; 0 = strict data priority.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request, level, held until granted.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  branch taken: discard in-flight fetch responses.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_valid  out  1  one-cycle pulse, if_data holds a fetched byte.
- if_data  out  DATA_W  fetched byte, held until next if_valid.
- dr_req  in  1  MOVC read request, level.
- dr_addr  in  ADDR_W  MOVC address.
- dr_gnt  out  1  MOVC request accepted this cycle (combinational).
- dr_valid  out  1  one-cycle pulse, dr_data valid.
- dr_data  out  DATA_W  MOVC byte, held until next dr_valid.
- rom_addr  out  ADDR_W  address to ROM.
- rom_rd  out  1  read strobe to ROM.
- rom_data  in  DATA_W  ROM output.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: if_gnt=0, dr_gnt=0, if_valid=0, dr_valid=0, if_data=0, dr_data=0, rom_rd=0, rom_addr=0. Reset also clears the tag pipeline, the streak counter and the init counter; FSM enters S_INIT.
- Reset mid-operation: all in-flight reads are dropped, and no valid pulse is produced for them.

FSM:
- S_INIT: no grants. Count INIT_CYCLES cycles after rst low, then go to S_RUN.
- S_RUN: arbitrate every cycle.

Arbitration in S_RUN (combinational from current-cycle requests):
- Only dr_req high: grant data.
- Only if_req high: grant fetch.
- Both high: grant data unless MAX_DR_STREAK≠0 and streak==MAX_DR_STREAK, in which case grant fetch.
- streak increments on each data grant while if_req is high (saturates at MAX_DR_STREAK). It clears on any fetch grant, or on any cycle with if_req low.
- At most one of if_gnt/dr_gnt is high per cycle.
- Granted cycle: rom_rd=1, rom_addr = granted requester's address.
- No grant: rom_rd=0, rom_addr holds its last value.

Response path:
- Tag pipeline has RD_LATENCY stages. Each entry holds {valid, owner}.
- At the edge where a tag exits the last stage, rom_data is captured into the owner's data register and that owner's valid pulses for one cycle.
- Total latency: grant in cycle N → valid high in cycle N+RD_LATENCY+1.
- Fully pipelined: back-to-back grants give back-to-back valids, in order.

Flush:
- if_flush high in cycle N clears the valid bit of every fetch-owned tag in the pipeline at the end of cycle N. Their data is not captured, and if_data keeps its old value.
- A fetch granted in the same cycle N is not killed.
- Data-owned tags are unaffected.
- if_flush with nothing in flight has no effect.

Simultaneous events:
- A valid pulse and a new grant in the same cycle are independent.
- if_req arriving during S_INIT waits and is granted in the first S_RUN cycle.

Test Plan:
- Reset/init: rst high 3 cycles, if_req=1 from reset release → if_gnt stays 0 for exactly INIT_CYCLES=2 cycles. Then if_gnt=1 with rom_rd=1, and all outputs read 0 during reset.
- Fetch stream: ROM model preloaded 0x24@0, 0x05@1, 0x20@2. Fetch addresses 0,1,2 back-to-back → if_valid on 3 consecutive cycles starting 2 cycles after the first grant, if_data = 0x24, 0x05, 0x20.
- Contention: if_req and dr_req both held high, MAX_DR_STREAK=4 → grant pattern D,D,D,D,F,D,D,D,D,F. With MAX_DR_STREAK=0 → data granted every cycle and fetch never granted.
- Flush: grant fetch @0x001, then if_flush pulsed in the cycle after the grant while fetch @0x002 is granted that same cycle → no if_valid for 0x001. One if_valid with data 0x20 arrives one cycle after the pulse 0x001 would have produced.
- Mixed ownership: dr @0x000 in cycle N, if @0x001 in cycle N+1, flush in N+1 → dr_valid with 0x24 in N+2 and if_valid with 0x05 in N+3. Data is routed to the correct owner and dr_data is unaffected by the flush.
- Reset mid-flight: grant at N, rst at N+1 → no valid in N+2, and all outputs are 0 at N+2.
